tdc_code_averager: RTL and testbench
====================================

// Module: tdc_code_averager
// PURPOSE
//  Receive-side back end of the TDC. Takes the raw thermometer code captured by the delay line,
//  decodes it to a binary delay value with bubble detection, and averages 2^AVG_LOG2 samples per run.
//  Returns one result over a valid/ready handshake. Sits between the TDC capture register and the
//  top-level output mux.
// PARAMETERS
//  THERM_W   32  thermometer code width (delay-line taps)
//  CNT_W     6   decoded value width; must hold THERM_W (clog2(THERM_W+1))
//  AVG_LOG2  3   log2 of samples averaged per run (0..6)
// PORTS
//  clk             in   1        single clock; all logic rising-edge
//  rst             in   1        synchronous, active-high reset
//  start_i         in   1        begin a run (honoured only in IDLE)
//  sample_valid_i  in   1        therm_i valid this cycle
//  therm_i         in   THERM_W  raw thermometer code; bit0 = first tap
//  result_valid_o  out  1        averaged result available
//  result_ready_i  in   1        consumer accepts result
//  result_o        out  CNT_W    rounded average delay
//  busy_o          out  1        high in any state other than IDLE
//  bubble_cnt_o    out  8        saturating count of bubbled codes in current/last run
//  sat_o           out  1        sticky per run: an all-ones code was seen
//  min_o/max_o     out  CNT_W    only with TDC_MINMAX_EN
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0; acc, sample count and pipeline valid cleared.
//    Applies from any state, mid-run included; a partial run is discarded.
//  Decode (registered, 1-cycle latency): value = number of consecutive 1s from bit0 (leading-ones).
//    Any 1 above the first 0 is a bubble: bubble_cnt_o += 1, saturating at 255.
//    0x0 -> 0. All ones -> THERM_W and sets sat_o.
//  FSM IDLE -> ACCUM -> DIV -> HOLD -> IDLE.
//   IDLE:  start_i=1 -> ACCUM. On that edge, clear acc, sample count, bubble_cnt_o, sat_o
//          (and min/max). result_o keeps its last value.
//   ACCUM: each sample_valid_i counts as accepted until 2^AVG_LOG2 samples are taken;
//          later samples are dropped. acc (CNT_W+AVG_LOG2 bits, cannot overflow) adds each
//          decoded value 1 cycle after acceptance. -> DIV on the cycle the last decoded value is added.
//   DIV:   result_o <= (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2 (no rounding term if AVG_LOG2=0).
//          Result saturates at THERM_W. -> HOLD (1 cycle).
//   HOLD:  result_valid_o=1. result_o, bubble_cnt_o, sat_o stable until result_ready_i=1,
//          then -> IDLE with result_valid_o=0 next cycle.
//  start_i outside IDLE ignored. sample_valid_i outside ACCUM ignored.
//  A start_i in the IDLE cycle right after handshake is honoured (back-to-back runs).
//  Min latency with samples every cycle: last sample at t -> result_valid_o at t+3.
// CONFIGURATION
//  TDC_MINMAX_EN defined:
//    - min_o/max_o track min/max decoded value over the run.
//    - Init THERM_W/0 at run start; min_o=0, max_o=0 on reset.
//    - Updated with acc; held with result.
//  TDC_MINMAX_EN undefined: min_o/max_o ports and logic absent.
// STRUCTURE
//  Package tdc_pkg: state enum (IDLE, ACCUM, DIV, HOLD), default THERM_W/CNT_W/AVG_LOG2, BUBBLE_CNT_W=8.
//  Sub-module tdc_therm2bin: combinational leading-ones decode + bubble + all-ones flags.
//  Registered in this block.
// TESTING (THERM_W=32, AVG_LOG2=3)
//  1. start, 8 x 0x000000FF ->
//     result_o=8, result_valid_o held with ready=0 for 5 cycles, then drops after ready.
//  2. 4 x 0x0000000F + 4 x 0x0000001F (sum 36) ->
//     result_o=5 (rounded (36+4)>>3). bubble_cnt_o=0.
//  3. 8 x 0x000000F7 ->
//     result_o=3, bubble_cnt_o=8. 8 x 0xFFFFFFFF -> result_o=32, sat_o=1.
//  4. rst after 3 samples in ACCUM ->
//     next cycle busy_o=0, outputs 0. New start needs a full 8 samples. Extra samples after the 8th are ignored.
//  5. sample_valid_i in IDLE/HOLD, start_i during ACCUM -> no effect. start_i in cycle after handshake starts next run.
//  6. TDC_MINMAX_EN: values 2,9,5,... -> min_o=2, max_o=9. Without macro: build has no min_o/max_o ports.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the TDC receive back end.
// No logic, so no latency or backpressure.
// The state enum, default widths and bubble counter width live here.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIV   = 2'd2,
        HOLD  = 2'd3
    } tdc_state_t;

    localparam int TDC_THERM_W  = 32;
    localparam int TDC_CNT_W    = 6;
    localparam int TDC_AVG_LOG2 = 3;
    localparam int BUBBLE_CNT_W = 8;

endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer-to-binary decode: counts leading ones from bit0, flags bubbles and the all-ones code.
// Latency: purely combinational; the caller registers the outputs.
// Backpressure: none (no handshake).
module tdc_therm2bin #(
    parameter int THERM_W = 32,
    parameter int CNT_W   = 6
) (
    input  logic [THERM_W-1:0] therm,
    output logic [CNT_W-1:0]   value,
    output logic               bubble,
    output logic               all_ones
);

    logic found_zero;

    // Once the first 0 is seen the count freezes; any later 1 is a bubble.
    always_comb begin
        value      = '0;
        bubble     = 1'b0;
        found_zero = 1'b0;
        for (int i = 0; i < THERM_W; i++) begin
            if (!therm[i]) begin
                found_zero = 1'b1;
            end else if (found_zero) begin
                bubble = 1'b1;
            end else begin
                value = CNT_W'(i + 1);
            end
        end
    end

    assign all_ones = &therm;

endmodule

// File: rtl/tdc_code_averager.sv
// Decodes TDC thermometer codes and returns the rounded average of 2^AVG_LOG2 samples per run.
// Latency: last accepted sample at t -> result_valid_o at t+3. Optional min/max: TDC_MINMAX_EN.
// Backpressure: result held in HOLD until result_ready_i; samples beyond the run count are dropped.
module tdc_code_averager
    import tdc_pkg::*;
#(
    parameter int THERM_W  = TDC_THERM_W,
    parameter int CNT_W    = TDC_CNT_W,
    parameter int AVG_LOG2 = TDC_AVG_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    sample_valid_i,
    input  logic [THERM_W-1:0]      therm_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [CNT_W-1:0]        result_o,
    output logic                    busy_o,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o,
`ifdef TDC_MINMAX_EN
    output logic [CNT_W-1:0]        min_o,
    output logic [CNT_W-1:0]        max_o,
`endif
    output logic                    sat_o
);

    localparam int NSAMP  = 1 << AVG_LOG2;
    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int TAKE_W = AVG_LOG2 + 1;
    localparam int RND_W  = ACC_W + 1;
    localparam int HALF   = NSAMP >> 1;

    tdc_state_t state, state_nxt;

    logic [TAKE_W-1:0] take_cnt;
    logic              accept;
    logic              last_add;

    logic [CNT_W-1:0]  t2b_val;
    logic              t2b_bub;
    logic              t2b_sat;

    logic              dec_vld;
    logic [CNT_W-1:0]  dec_val;
    logic              dec_bub;
    logic              dec_sat;

    logic [ACC_W-1:0]  acc;
    logic [RND_W-1:0]  rounded;
    logic [CNT_W-1:0]  result_nxt;

    tdc_therm2bin #(
        .THERM_W (THERM_W),
        .CNT_W   (CNT_W)
    ) u_therm2bin (
        .therm    (therm_i),
        .value    (t2b_val),
        .bubble   (t2b_bub),
        .all_ones (t2b_sat)
    );

    assign accept   = (state == ACCUM) && sample_valid_i && (take_cnt != TAKE_W'(NSAMP));
    // Decode is one cycle behind acceptance, so the first decoded value seen
    // with the take count full is the last one of the run.
    assign last_add = dec_vld && (take_cnt == TAKE_W'(NSAMP));

    assign rounded    = ({1'b0, acc} + RND_W'(HALF)) >> AVG_LOG2;
    assign result_nxt = (rounded > RND_W'(THERM_W)) ? CNT_W'(THERM_W) : rounded[CNT_W-1:0];

    assign busy_o         = (state != IDLE);
    assign result_valid_o = (state == HOLD);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)        state_nxt = ACCUM;
            ACCUM:   if (last_add)       state_nxt = DIV;
            DIV:                         state_nxt = HOLD;
            HOLD:    if (result_ready_i) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            take_cnt     <= '0;
            dec_vld      <= 1'b0;
            dec_val      <= '0;
            dec_bub      <= 1'b0;
            dec_sat      <= 1'b0;
            acc          <= '0;
            result_o     <= '0;
            bubble_cnt_o <= '0;
            sat_o        <= 1'b0;
        end else begin
            state   <= state_nxt;
            dec_vld <= accept;
            if (accept) begin
                dec_val  <= t2b_val;
                dec_bub  <= t2b_bub;
                dec_sat  <= t2b_sat;
                take_cnt <= take_cnt + TAKE_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc          <= '0;
                        take_cnt     <= '0;
                        bubble_cnt_o <= '0;
                        sat_o        <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (dec_vld) begin
                        acc <= acc + ACC_W'(dec_val);
                        if (dec_bub && (bubble_cnt_o != '1)) begin
                            bubble_cnt_o <= bubble_cnt_o + 1'b1;
                        end
                        if (dec_sat) begin
                            sat_o <= 1'b1;
                        end
                    end
                end
                DIV:     result_o <= result_nxt;
                default: ;
            endcase
        end
    end

`ifdef TDC_MINMAX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            min_o <= '0;
            max_o <= '0;
        end else if ((state == IDLE) && start_i) begin
            min_o <= CNT_W'(THERM_W);
            max_o <= '0;
        end else if ((state == ACCUM) && dec_vld) begin
            if (dec_val < min_o) min_o <= dec_val;
            if (dec_val > max_o) max_o <= dec_val;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_code_averager.sv
// Directed bench for tdc_code_averager with a run-level reference model and per-cycle result checking.
`timescale 1ns/1ps
module tb_tdc_code_averager;

    localparam int THERM_W = 32;
    localparam int CNT_W   = 6;
    localparam int NSAMP   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               sample_valid_i;
    logic [THERM_W-1:0] therm_i;
    logic               result_valid_o;
    logic               result_ready_i;
    logic [CNT_W-1:0]   result_o;
    logic               busy_o;
    logic [7:0]         bubble_cnt_o;
    logic               sat_o;
`ifdef TDC_MINMAX_EN
    logic [CNT_W-1:0]   min_o;
    logic [CNT_W-1:0]   max_o;
`endif

    always #5 clk = ~clk;

    tdc_code_averager dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .sample_valid_i (sample_valid_i),
        .therm_i        (therm_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .busy_o         (busy_o),
        .bubble_cnt_o   (bubble_cnt_o),
`ifdef TDC_MINMAX_EN
        .min_o          (min_o),
        .max_o          (max_o),
`endif
        .sat_o          (sat_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int res;
        int bub;
        int sat;
        int mn;
        int mx;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] run_codes[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lead_ones(input logic [31:0] c);
        int v = 0;
        while (v < THERM_W && c[v]) v++;
        return v;
    endfunction

    task automatic start_run();
        run_codes.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Only the first NSAMP samples of a run are part of the expected average.
    task automatic feed(input logic [31:0] code);
        sample_valid_i = 1'b1;
        therm_i        = code;
        if (run_codes.size() < NSAMP) run_codes.push_back(code);
        tick();
        sample_valid_i = 1'b0;
        therm_i        = '0;
    endtask

    task automatic end_run();
        exp_t e;
        int   sum = 0;
        e.bub = 0;
        e.sat = 0;
        e.mn  = THERM_W;
        e.mx  = 0;
        foreach (run_codes[k]) begin
            int v;
            v = lead_ones(run_codes[k]);
            sum += v;
            if (v == THERM_W) e.sat = 1;
            else if ((run_codes[k] >> v) != 0) e.bub = (e.bub < 255) ? e.bub + 1 : 255;
            if (v < e.mn) e.mn = v;
            if (v > e.mx) e.mx = v;
        end
        e.res = (sum + NSAMP / 2) / NSAMP;
        if (e.res > THERM_W) e.res = THERM_W;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid_o && n < 30) begin
            tick();
            n++;
        end
        if (!result_valid_o) check("valid_timeout", result_valid_o, 1);
    endtask

    task automatic accept();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    // Compare process: every cycle a result is offered it must match the model's next run.
    always @(negedge clk) begin
        if (!rst && result_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", result_valid_o, 0);
            end else begin
                check("model_result", result_o, exp_q[0].res);
                check("model_bubble", bubble_cnt_o, exp_q[0].bub);
                check("model_sat", sat_o, exp_q[0].sat);
                check("model_busy", busy_o, 1);
`ifdef TDC_MINMAX_EN
                check("model_min", min_o, exp_q[0].mn);
                check("model_max", max_o, exp_q[0].mx);
`endif
                if (result_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst            = 1'b1;
        start_i        = 1'b0;
        sample_valid_i = 1'b0;
        therm_i        = '0;
        result_ready_i = 1'b0;
        repeat (2) tick();
        check("reset_busy", busy_o, 0);
        check("reset_valid", result_valid_o, 0);
        check("reset_result", result_o, 0);
        check("reset_bubble", bubble_cnt_o, 0);
        check("reset_sat", sat_o, 0);
        rst = 1'b0;
        tick();

        // 1: eight 0xFF codes, held result under backpressure
        start_run();
        for (int i = 0; i < NSAMP; i++) feed(32'h0000_00FF);
        end_run();
        wait_valid(n);
        check("t1_latency", n, 2);
        check("t1_result", result_o, 8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_valid", result_valid_o, 1);
        end
        accept();
        check("t1_valid_drop", result_valid_o, 0);
        check("t1_idle", busy_o, 0);

        // 2: mixed values, rounding
        start_run();
        for (int i = 0; i < 4; i++) feed(32'h0000_000F);
        for (int i = 0; i < 4; i++) feed(32'h0000_001F);
        end_run();
        wait_valid(n);
        check("t2_result", result_o, 5);
        check("t2_bubble", bubble_cnt_o, 0);
        accept();

        // 3: bubbled codes, then all-ones
        start_run();
        for (int i = 0; i < NSAMP; i++) feed(32'h0000_00F7);
        end_run();
        wait_valid(n);
        check("t3_result", result_o, 3);
        check("t3_bubble", bubble_cnt_o, 8);
        check("t3_sat_clear", sat_o, 0);
        accept();
        start_run();
        for (int i = 0; i < NSAMP; i++) feed(32'hFFFF_FFFF);
        end_run();
        wait_valid(n);
        check("t3_full_result", result_o, 32);
        check("t3_sat", sat_o, 1);
        accept();

        // 4: reset mid-run, then a fresh run needs all eight samples
        start_run();
        for (int i = 0; i < 3; i++) feed(32'h0000_00FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", busy_o, 0);
        check("t4_valid", result_valid_o, 0);
        check("t4_result", result_o, 0);
        check("t4_bubble", bubble_cnt_o, 0);
        check("t4_sat", sat_o, 0);
        start_run();
        for (int i = 0; i < 7; i++) feed(32'h0000_0007);
        repeat (4) tick();
        check("t4_not_early", result_valid_o, 0);
        check("t4_still_busy", busy_o, 1);
        feed(32'h0000_0001);
        feed(32'hFFFF_FFFF);
        feed(32'hFFFF_FFFF);
        end_run();
        wait_valid(n);
        check("t4_result_full", result_o, 3);
        check("t4_extra_ignored", sat_o, 0);
        accept();

        // 5: samples in IDLE/HOLD and start in ACCUM ignored; back-to-back start
        sample_valid_i = 1'b1;
        therm_i        = 32'hFFFF_FFFF;
        tick();
        sample_valid_i = 1'b0;
        check("t5_idle_sample", busy_o, 0);
        start_run();
        feed(32'h0000_001F);
        start_i = 1'b1;
        feed(32'h0000_001F);
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) feed(32'h0000_001F);
        end_run();
        wait_valid(n);
        sample_valid_i = 1'b1;
        therm_i        = 32'hFFFF_FFFF;
        repeat (2) tick();
        sample_valid_i = 1'b0;
        check("t5_hold_result", result_o, 5);
        check("t5_hold_sat", sat_o, 0);
        accept();
        start_run();
        check("t5_back_to_back", busy_o, 1);
        for (int i = 0; i < NSAMP; i++) feed(32'h0000_0000);
        end_run();
        wait_valid(n);
        check("t5_zero_result", result_o, 0);
        accept();

        // 6: value spread, min 2 / max 9
        start_run();
        feed(32'h0000_0003);
        feed(32'h0000_01FF);
        feed(32'h0000_001F);
        feed(32'h0000_0007);
        feed(32'h0000_000F);
        feed(32'h0000_003F);
        feed(32'h0000_0007);
        feed(32'h0000_000F);
        end_run();
        wait_valid(n);
        check("t6_result", result_o, 5);
`ifdef TDC_MINMAX_EN
        check("t6_min", min_o, 2);
        check("t6_max", max_o, 9);
`endif
        accept();

        repeat (3) tick();
        check("all_results_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
